dm_arbiter: RTL and testbench

- Shares the single-port word-addressed data memory between two requesters: port A (CPU load/store) and port B (DMA/debug loader).
- Round-robin arbitration with valid/ready request handshake; responses are one-cycle pulses.
- Sits between the requesters and the data memory; drives the memory's address, write-data, write-enable and PC inputs, and samples its combinational read data.

---
 rtl/dm_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
`timescale 1ns/1ps
// dm_arbiter
// ---------------------------------------------------------------------------
// Shares the single-port, word-addressed data memory between two requesters:
// port A (CPU load/store) and port B (DMA / debug loader). Round-robin
// arbitration; every transaction takes three cycles: IDLE (accept),
// ACCESS (memory driven, write commits at the edge leaving it),
// RESP (one-cycle response pulse to the owner).
//
// Handshake: a requester raises *_valid and holds *_we/*_addr/*_wdata (and
// a_pc) stable until it sees *_ready high in the same cycle; the request is
// accepted at the rising edge that ends that cycle. Exactly one *_resp_valid
// pulse follows each accept, two cycles later. *_ready is only ever high in
// IDLE and never while reset is asserted.
//
// Optional feature (macro DM_ARB_ALIGN_CHK_EN): misaligned requests
// (addr[1:0] != 0) are still sequenced, but never write memory, respond with
// rdata = 0 and raise resp_err alongside the owner's resp_valid. Without the
// macro resp_err is tied low and addresses are forwarded untouched.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   a_valid/a_ready/a_we/a_addr/a_wdata/a_pc   port A request
//   a_resp_valid/a_rdata        port A response
//   b_valid/b_ready/b_we/b_addr/b_wdata        port B request
//   b_resp_valid/b_rdata        port B response
//   resp_err                    misaligned flag, qualifies the response pulse
//   mem_addr/mem_wdata/mem_we/mem_pc   memory drive
//   mem_rdata                   memory combinational read data
//   fsm_state                   current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter logic [31:0] B_PC_TAG = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [31:0]   a_pc,
  output logic          a_resp_valid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_resp_valid,
  output logic [DW-1:0] b_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [31:0]   mem_pc,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q;
  logic          last_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [31:0]   pc_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic          pick_a, pick_b;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [31:0]   sel_pc;
  logic          sel_err;

  // A lone requester always wins; on a tie the port that did not win last.
  assign pick_a = a_valid && (!b_valid || (last_q == PORT_B));
  assign pick_b = b_valid && (!a_valid || (last_q == PORT_A));

  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;
  assign sel_pc    = pick_b ? B_PC_TAG : a_pc;

`ifdef DM_ARB_ALIGN_CHK_EN
  assign sel_err = (sel_addr[1:0] != 2'b00);
`else
  assign sel_err = 1'b0;
`endif

  // Next-state and outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gating with reset keeps ready low while reset is held.
        a_ready = reset && pick_a;
        b_ready = reset && pick_b;
        accept  = pick_a || pick_b;
        if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= PORT_A;
      last_q  <= PORT_B;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= pick_b;
        last_q  <= pick_b;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        pc_q    <= sel_pc;
        err_q   <= sel_err;
      end
      // For writes this captures the old word; it is never qualified as data.
      if (state_q == S_ACCESS) rdata_q <= err_q ? '0 : mem_rdata;
    end
  end

  // Memory side is driven from the latched request only, so it never follows
  // the requester inputs. mem_we depends on state_q alone and therefore drops
  // as soon as reset asserts.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_pc    = pc_q;
  assign mem_we    = (state_q == S_ACCESS) && we_q && !err_q;

  assign a_resp_valid = (state_q == S_RESP) && (owner_q == PORT_A);
  assign b_resp_valid = (state_q == S_RESP) && (owner_q == PORT_B);
  assign a_rdata      = rdata_q;
  assign b_rdata      = rdata_q;
  assign resp_err     = (state_q == S_RESP) && err_q;

  assign fsm_state = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
`timescale 1ns/1ps
// Bench for dm_arbiter: directed requests on both ports against a small
// word memory model; responses are checked by a monitor from an expected queue.
module tb_dm_arbiter;
  localparam logic [31:0] TAG = 32'hB0B0_0000;

  logic        clk, reset;
  logic        a_valid, a_ready, a_we, a_resp_valid;
  logic [31:0] a_addr, a_wdata, a_pc, a_rdata;
  logic        b_valid, b_ready, b_we, b_resp_valid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        resp_err, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [1:0]  fsm_state;

  dm_arbiter #(.AW(32), .DW(32), .B_PC_TAG(TAG)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_pc(a_pc), .a_resp_valid(a_resp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_resp_valid(b_resp_valid), .b_rdata(b_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_pc(mem_pc), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  // ---------------- scoreboard ----------------
  // entry = {check_data, exp_err, exp_port(0=A,1=B), exp_data}
  logic [34:0] exp_q[$];
  int          grant_cyc[$];
  logic        grant_port[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (a_resp_valid || b_resp_valid) check("resp_in_reset", 32'd1, 32'd0);
    end else if (a_resp_valid && b_resp_valid) begin
      check("both_resp", 32'd1, 32'd0);
    end else if (a_resp_valid || b_resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'd0, b_resp_valid}, 32'hFFFF_FFFF);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("resp_port", {31'd0, b_resp_valid}, {31'd0, e[32]});
        check("resp_err", {31'd0, resp_err}, {31'd0, e[33]});
        if (e[34]) check("resp_rdata", b_resp_valid ? b_rdata : a_rdata, e[31:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  // Return at posedge+1 of the accepting edge (DUT then in ACCESS).
  task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic [31:0] exp_data,
                       input logic exp_err, input logic chk, input logic want_resp);
    logic got = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_pc = pc;
    for (int n = 0; n < 60 && !got; n++) begin
      #1;
      if (a_ready) begin
        got = 1'b1;
        grant_cyc.push_back(cyc);
        grant_port.push_back(1'b0);
        if (want_resp) exp_q.push_back({chk, exp_err, 1'b0, exp_data});
        @(posedge clk); #1;
      end else begin
        @(negedge clk);
      end
    end
    a_valid = 1'b0;
    check("a_ready_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic b_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic chk);
    logic got = 1'b0;
    @(negedge clk);
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    for (int n = 0; n < 60 && !got; n++) begin
      #1;
      if (b_ready) begin
        got = 1'b1;
        grant_cyc.push_back(cyc);
        grant_port.push_back(1'b1);
        exp_q.push_back({chk, 1'b0, 1'b1, exp_data});
        @(posedge clk); #1;
      end else begin
        @(negedge clk);
      end
    end
    b_valid = 1'b0;
    check("b_ready_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = '0; a_pc = '0;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h20; b_wdata = '0;
    repeat (3) @(negedge clk);
    // reset state: ready held low even with both valid
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: A write, cycle accounting, then read back
    a_req(1'b1, 32'h10, 32'h1234_5678, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 1'b1);
    check("t1_access_we", {31'd0, mem_we}, 32'd1);
    check("t1_access_addr", mem_addr, 32'h10);
    check("t1_access_wdata", mem_wdata, 32'h1234_5678);
    check("t1_access_pc", mem_pc, 32'h0000_0400);
    check("t1_access_state", {30'd0, fsm_state}, 32'd1);
    @(posedge clk); #1;
    check("t1_resp_we", {31'd0, mem_we}, 32'd0);
    check("t1_resp_valid", {31'd0, a_resp_valid}, 32'd1);
    check("t1_resp_hold_addr", mem_addr, 32'h10);
    a_req(1'b0, 32'h10, 32'h0, 32'h0000_0404, 32'h1234_5678, 1'b0, 1'b1, 1'b1);

    // 3: B write carries the B pc tag, A reads it back
    b_req(1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("t3_b_pc_tag", mem_pc, TAG);
    check("t3_b_we", {31'd0, mem_we}, 32'd1);
    a_req(1'b0, 32'h20, 32'h0, 32'h0000_0408, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);

    // 5: only B requesting (last winner was A): granted every 3 cycles
    grant_cyc.delete(); grant_port.delete();
    b_req(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b1);
    b_req(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b1);
    b_req(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b1);
    check("t5_grants", grant_cyc.size(), 32'd3);
    for (int i = 1; i < grant_cyc.size(); i++)
      check("t5_spacing", grant_cyc[i] - grant_cyc[i-1], 32'd3);

    // 2: both continuously valid, last winner was B: A,B,A,B
    grant_cyc.delete(); grant_port.delete();
    fork
      begin
        a_req(1'b1, 32'h100, 32'h0000_00A1, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 1'b1);
        a_req(1'b0, 32'h104, 32'h0, 32'h0000_0504, 32'h0000_00B1, 1'b0, 1'b1, 1'b1);
      end
      begin
        b_req(1'b1, 32'h104, 32'h0000_00B1, 32'h0, 1'b0);
        b_req(1'b0, 32'h100, 32'h0, 32'h0000_00A1, 1'b1);
      end
    join
    check("t2_grants", grant_cyc.size(), 32'd4);
    for (int i = 0; i < grant_port.size() && i < 4; i++)
      check("t2_order", {31'd0, grant_port[i]}, {31'd0, exp_order[i]});
    for (int i = 1; i < grant_cyc.size(); i++)
      check("t2_spacing", grant_cyc[i] - grant_cyc[i-1], 32'd3);

    // 4: reset during ACCESS of an A write abandons it
    a_req(1'b1, 32'h30, 32'hFFFF_FFFF, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t4_we_before", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t4_we_async_drop", {31'd0, mem_we}, 32'd0);
    check("t4_state_idle", {30'd0, fsm_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_no_pending", exp_q.size(), 32'd0);
    a_req(1'b0, 32'h30, 32'h0, 32'h0000_0604, 32'h0, 1'b0, 1'b1, 1'b1);

    // 6: misaligned write
`ifdef DM_ARB_ALIGN_CHK_EN
    a_req(1'b1, 32'h42, 32'h5555_5555, 32'h0000_0700, 32'h0, 1'b1, 1'b1, 1'b1);
    check("t6_we_blocked", {31'd0, mem_we}, 32'd0);
    a_req(1'b0, 32'h40, 32'h0, 32'h0000_0704, 32'h0, 1'b0, 1'b1, 1'b1);
`else
    a_req(1'b1, 32'h42, 32'h5555_5555, 32'h0000_0700, 32'h0, 1'b0, 1'b0, 1'b1);
    check("t6_we_passes", {31'd0, mem_we}, 32'd1);
    a_req(1'b0, 32'h40, 32'h0, 32'h0000_0704, 32'h5555_5555, 1'b0, 1'b1, 1'b1);
`endif

    repeat (6) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
